// File: rtl/cert_chunk_responder.sv
// Serves byte ranges of per-slot certificate chains from a synchronous ROM as output beats.
// Define CERT_RESP_CHECKSUM_EN to append an XOR checksum beat after the data.
`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h12
`endif
`ifndef CERTIFICATE_ANSWER_CMD
`define CERTIFICATE_ANSWER_CMD 8'h02
`endif

module cert_chunk_responder #(
  parameter int NUM_SLOTS  = 3,
  parameter int BEAT_BYTES = 4,
  parameter int SLOT_DEPTH = 512,
  parameter int MAX_LEN    = 1024,
  localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int ADDR_W    = $clog2(NUM_SLOTS * SLOT_DEPTH),
  localparam int DW        = 8 * BEAT_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [SLOT_W-1:0]       req_slot,
  input  logic [15:0]             req_offset,
  input  logic [15:0]             req_length,
  input  logic [16*NUM_SLOTS-1:0] slot_len_tbl,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DW-1:0]           rom_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
  output logic                    out_last,
  output logic [31:0]             out_header,
  output logic                    err_invalid,
  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, CHECK, FETCH, SEND, ERR} state_t;

  localparam logic [15:0] BB16      = 16'(BEAT_BYTES);
  localparam logic [16:0] MAX_LEN_V = 17'(MAX_LEN);

  state_t              state_r;
  logic [SLOT_W-1:0]   slot_r;
  logic [15:0]         off_r;
  logic [15:0]         len_r;
  logic [15:0]         cnt_r;
  logic                loaded_r;
`ifdef CERT_RESP_CHECKSUM_EN
  logic [DW-1:0]       chk_r;
`endif

  logic [15:0]         tbl_len_s;
  logic                check_ok_s;
  logic [ADDR_W-1:0]   first_addr_s;
  logic [15:0]         beats_s;
  logic [15:0]         tail_s;
  logic [DW-1:0]       beat_data_s;

  function automatic logic [DW-1:0] mask_beat(input logic [DW-1:0] d, input logic [15:0] nbytes);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      if (16'(i) < nbytes) m[i*8 +: 8] = d[i*8 +: 8];
      else                 m[i*8 +: 8] = 8'h00;
    end
    return m;
  endfunction

  // Request validation, first address, beat count and last-beat masking
  always_comb begin
    tbl_len_s = 16'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (int'(slot_r) == i) tbl_len_s = slot_len_tbl[i*16 +: 16];
      else                   tbl_len_s = tbl_len_s;
    end
    // the range sum is kept 17 bits wide so a large offset cannot wrap past the table length
    check_ok_s = (int'(slot_r) < NUM_SLOTS) && (len_r != 16'd0) &&
                 ({1'b0, len_r} <= MAX_LEN_V) && ((off_r % BB16) == 16'd0) &&
                 (({1'b0, off_r} + {1'b0, len_r}) <= {1'b0, tbl_len_s});
    first_addr_s = ADDR_W'(slot_r) * ADDR_W'(SLOT_DEPTH) + ADDR_W'(off_r / BB16);
    beats_s      = 16'(({1'b0, len_r} + 17'(BEAT_BYTES - 1)) / 17'(BEAT_BYTES));
    tail_s       = len_r % BB16;
    beat_data_s  = mask_beat(rom_data, ((cnt_r == 16'd1) && (tail_s != 16'd0)) ? tail_s : BB16);
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      slot_r      <= '0;
      off_r       <= 16'd0;
      len_r       <= 16'd0;
      cnt_r       <= 16'd0;
      loaded_r    <= 1'b0;
      req_ready   <= 1'b0;
      rom_addr    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_header  <= 32'd0;
      err_invalid <= 1'b0;
      busy        <= 1'b0;
`ifdef CERT_RESP_CHECKSUM_EN
      chk_r       <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            slot_r    <= req_slot;
            off_r     <= req_offset;
            len_r     <= req_length;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state_r   <= CHECK;
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        CHECK: begin
          if (check_ok_s) begin
            cnt_r    <= beats_s;
            rom_addr <= first_addr_s;
            state_r  <= FETCH;
`ifdef CERT_RESP_CHECKSUM_EN
            chk_r    <= '0;
`endif
          end else begin
            err_invalid <= 1'b1;
            state_r     <= ERR;
          end
        end
        FETCH: begin
          loaded_r <= 1'b0;
          state_r  <= SEND;
        end
        SEND: begin
          // ROM data lands one cycle into SEND; capture it once, then hold until accepted
          if (!loaded_r) begin
            loaded_r   <= 1'b1;
            out_valid  <= 1'b1;
            out_data   <= beat_data_s;
            out_header <= {`PROTOCOL_VERSION, `CERTIFICATE_ANSWER_CMD, 8'(slot_r), 8'h00};
`ifdef CERT_RESP_CHECKSUM_EN
            out_last   <= 1'b0;
`else
            out_last   <= (cnt_r == 16'd1);
`endif
          end else if (out_ready) begin
            if (out_last) begin
              out_valid  <= 1'b0;
              out_data   <= '0;
              out_last   <= 1'b0;
              out_header <= 32'd0;
              req_ready  <= 1'b1;
              busy       <= 1'b0;
              state_r    <= IDLE;
            end
`ifdef CERT_RESP_CHECKSUM_EN
            else if (cnt_r == 16'd1) begin
              out_data <= chk_r ^ out_data;
              out_last <= 1'b1;
            end
`endif
            else begin
              out_valid  <= 1'b0;
              out_data   <= '0;
              out_header <= 32'd0;
              cnt_r      <= cnt_r - 16'd1;
              rom_addr   <= rom_addr + ADDR_W'(1);
              state_r    <= FETCH;
`ifdef CERT_RESP_CHECKSUM_EN
              chk_r      <= chk_r ^ out_data;
`endif
            end
          end else begin
            loaded_r <= loaded_r;
          end
        end
        ERR: begin
          err_invalid <= 1'b0;
          req_ready   <= 1'b1;
          busy        <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
